redmule_sim_ctrl: RTL and testbench

Synthesizable memory-mapped responder for the core's data port at the 0x8000_0000 region. It is the target end of the core's exit-code and putchar writes, and replaces behavioural decode in benches and FPGA builds. It speaks the TCDM request/grant/r_valid protocol as the slave side. It exposes an exit-code register, a putchar FIFO drained through a valid/ready byte stream, and a readable cycle counter.

---
 rtl/redmule_sim_ctrl_pkg.sv | 28 ++
 rtl/redmule_sim_ctrl_fifo.sv | 73 +++++++
 rtl/redmule_sim_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_redmule_sim_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_sim_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// redmule_sim_ctrl_pkg
// Shared definitions for the simulation-control responder: register indices
// (decoded from add_i[4:2]), reset/timeout exit codes and the registered
// response bundle.
// -----------------------------------------------------------------------------
package redmule_sim_ctrl_pkg;

  // Register indices, selected by add_i[4:2].
  localparam logic [2:0] EXIT     = 3'd0;
  localparam logic [2:0] PUTCHAR  = 3'd1;
  localparam logic [2:0] CYCLE_LO = 3'd2;
  localparam logic [2:0] CYCLE_HI = 3'd3;
  localparam logic [2:0] STATUS   = 3'd4;

  // Exit code before any write; all-ones means "never reported".
  localparam logic [31:0] EXIT_RESET_VAL = 32'hFFFF_FFFF;

  // Exit code loaded by the watchdog when it fires.
  localparam logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001;

  // One-cycle-delayed response to a granted request.
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } resp_t;

endpackage : redmule_sim_ctrl_pkg

// File: rtl/redmule_sim_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// redmule_sim_ctrl_fifo
// Byte FIFO holding putchar output until the consumer drains it.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i/data_i  enqueue one byte (ignored when full without a pop)
//   pop_i          dequeue the head byte (ignored when empty)
//   data_o         head byte, 0 while empty
//   full_o/empty_o occupancy flags
//   count_o        occupancy, width log2(DEPTH)+1
//
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
// -----------------------------------------------------------------------------
module redmule_sim_ctrl_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned OCC_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [7:0]       data_i,
  input  logic             pop_i,
  output logic [7:0]       data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [OCC_W-1:0] count_o
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == OCC_W'(DEPTH));
  assign count_o = count;

  // A pop frees the slot this cycle, so a push into a full FIFO is legal then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head is forced to 0 while empty so stale storage never leaks out.
  assign data_o = empty_o ? 8'h00 : mem[rd_ptr];

  // NOTE: the storage array has no reset; validity is tracked by count, and
  // leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : redmule_sim_ctrl_fifo

// File: rtl/redmule_sim_ctrl.sv
// -----------------------------------------------------------------------------
// redmule_sim_ctrl
// Memory-mapped responder for the core data port in the 0x8000_0000 region.
// Target of the exit-code and putchar writes; TCDM req/gnt/r_valid slave.
//
// Register map (add_i[4:2]):
//   0 EXIT      W: exit code (be ignored), sets sticky exit_valid_o; R: code
//   1 PUTCHAR   W: push data_i[7:0] when be_i[0]; R: FIFO occupancy
//   2 CYCLE_LO  R: cnt[31:0], snapshots cnt[63:32] into the hi shadow
//   3 CYCLE_HI  R: hi shadow
//   4 STATUS    R: {29'b0, exit_valid, full, empty}
//   5-7         R: 0; writes ignored but granted
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_i/gnt_o/add_i/wen_i/     TCDM request side (wen_i=1 is a read)
//   be_i/data_i
//   r_data_o/r_valid_o           response, one cycle after grant
//   exit_valid_o/exit_code_o     exit-code register
//   char_valid_o/char_o/         putchar byte stream
//   char_ready_i
//   timeout_o                    watchdog flag (REDMULE_SIM_CTRL_TIMEOUT_EN only)
//
// Optional feature: define REDMULE_SIM_CTRL_TIMEOUT_EN to add a watchdog that,
// after TIMEOUT_CYCLES cycles with no exit reported, raises timeout_o and
// reports exit code TIMEOUT_CODE.
// -----------------------------------------------------------------------------
module redmule_sim_ctrl
  import redmule_sim_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned CNT_W          = 64
`ifdef REDMULE_SIM_CTRL_TIMEOUT_EN
  , parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] add_i,
  input  logic        wen_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] data_i,
  output logic [31:0] r_data_o,
  output logic        r_valid_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_code_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i
`ifdef REDMULE_SIM_CTRL_TIMEOUT_EN
  , output logic      timeout_o
`endif
);

  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]       idx;
  logic             putchar_wr;
  logic             exit_wr;
  logic             lo_rd;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OCC_W-1:0] fifo_count;
  logic [31:0]      rd_val;
  resp_t            resp_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_shadow;
  logic             exit_valid_q;
  logic [31:0]      exit_code_q;

  // Address bits outside [4:2] and the upper byte enables carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{add_i[31:5], add_i[1:0], be_i[3:1]};

  assign idx        = add_i[4:2];
  assign putchar_wr = req_i && !wen_i && (idx == PUTCHAR);
  assign fifo_pop   = char_valid_o && char_ready_i;

  // Only a putchar write into a full FIFO with no simultaneous drain stalls.
  assign gnt_o = req_i && !(putchar_wr && fifo_full && !fifo_pop);

  assign fifo_push = gnt_o && putchar_wr && be_i[0];
  assign exit_wr   = gnt_o && !wen_i && (idx == EXIT);
  assign lo_rd     = gnt_o && wen_i && (idx == CYCLE_LO);

  redmule_sim_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (data_i[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (char_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign char_valid_o = !fifo_empty;

  // NOTE: rd_val gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_val = '0;
    case (idx)
      EXIT:     rd_val = exit_code_q;
      PUTCHAR:  rd_val = 32'(fifo_count);
      CYCLE_LO: rd_val = cnt[31:0];
      CYCLE_HI: rd_val = hi_shadow;
      STATUS:   rd_val = {29'b0, exit_valid_q, fifo_full, fifo_empty};
      default:  rd_val = '0;
    endcase
  end

  // Response register; writes and idle cycles return zero data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_q <= '0;
    end else begin
      resp_q.valid <= gnt_o;
      resp_q.data  <= (gnt_o && wen_i) ? rd_val : '0;
    end
  end

  assign r_valid_o = resp_q.valid;
  assign r_data_o  = resp_q.data;

  // Free-running cycle counter; the hi half is snapshotted on a LO read so a
  // LO/HI pair stays coherent across a carry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt       <= '0;
      hi_shadow <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (lo_rd) hi_shadow <= cnt[CNT_W-1:32];
    end
  end

`ifdef REDMULE_SIM_CTRL_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        timeout_q;
  logic        wd_fire;

  // Fires on the TIMEOUT_CYCLES-th cycle spent without an exit reported.
  assign wd_fire = !exit_valid_q && (wd_q == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!exit_valid_q && !wd_fire) wd_q <= wd_q + 32'd1;
      if (wd_fire) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`endif

  // Exit register; a software EXIT write in the same cycle as the watchdog
  // firing takes precedence for the code value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exit_valid_q <= 1'b0;
      exit_code_q  <= EXIT_RESET_VAL;
    end else begin
`ifdef REDMULE_SIM_CTRL_TIMEOUT_EN
      if (wd_fire) begin
        exit_valid_q <= 1'b1;
        exit_code_q  <= TIMEOUT_CODE;
      end
`endif
      if (exit_wr) begin
        exit_valid_q <= 1'b1;
        exit_code_q  <= data_i;
      end
    end
  end

  assign exit_valid_o = exit_valid_q;
  assign exit_code_o  = exit_code_q;

endmodule : redmule_sim_ctrl

// File: tb/tb_redmule_sim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_redmule_sim_ctrl
// Self-checking bench for redmule_sim_ctrl. A queue-based model of the register
// map is compared against every DUT output once per cycle; directed sequences
// add literal expectations on top. Define REDMULE_SIM_CTRL_TIMEOUT_EN to also
// exercise the watchdog with TIMEOUT_CYCLES=100.
// -----------------------------------------------------------------------------
module tb_redmule_sim_ctrl;

  localparam int DEPTH = 16;
`ifdef REDMULE_SIM_CTRL_TIMEOUT_EN
  localparam int TMO = 100;
`endif

  logic        clk;
  logic        rst_i;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] add_i;
  logic        wen_i;
  logic [3:0]  be_i;
  logic [31:0] data_i;
  logic [31:0] r_data_o;
  logic        r_valid_o;
  logic        exit_valid_o;
  logic [31:0] exit_code_o;
  logic        char_valid_o;
  logic [7:0]  char_o;
  logic        char_ready_i;
`ifdef REDMULE_SIM_CTRL_TIMEOUT_EN
  logic        timeout_o;
`endif

  redmule_sim_ctrl #(
    .FIFO_DEPTH (DEPTH)
`ifdef REDMULE_SIM_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES (32'd100)
`endif
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .add_i        (add_i),
    .wen_i        (wen_i),
    .be_i         (be_i),
    .data_i       (data_i),
    .r_data_o     (r_data_o),
    .r_valid_o    (r_valid_o),
    .exit_valid_o (exit_valid_o),
    .exit_code_o  (exit_code_o),
    .char_valid_o (char_valid_o),
    .char_o       (char_o),
    .char_ready_i (char_ready_i)
`ifdef REDMULE_SIM_CTRL_TIMEOUT_EN
    , .timeout_o  (timeout_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model ---
  byte unsigned m_fifo[$];
  logic         m_exit_valid;
  logic [31:0]  m_exit_code;
  logic [63:0]  m_cnt;
  logic [31:0]  m_shadow;
  logic         m_rv;
  logic [31:0]  m_rd;
  logic         m_tmo;
  int           m_wd;

  // Driver-owned: lets the force test tell the model what cnt holds.
  logic         cnt_forced = 1'b0;
  logic [63:0]  cnt_force_val = '0;

  function automatic void model_reset();
    m_fifo.delete();
    m_exit_valid = 1'b0;
    m_exit_code  = 32'hFFFF_FFFF;
    m_cnt        = '0;
    m_shadow     = '0;
    m_rv         = 1'b0;
    m_rd         = '0;
    m_tmo        = 1'b0;
    m_wd         = 0;
  endfunction

  // Single compare process: inputs change on negedge, outputs checked 1 time
  // unit later, then the model advances to the state after the next posedge.
  initial begin : compare
    logic        full, empty, pop, pc_wr, exp_gnt;
    logic [2:0]  ridx;
    logic [31:0] rv;
    model_reset();
    forever begin
      @(negedge clk);
      #1;
      if (rst_i) model_reset();
      if (cnt_forced) m_cnt = cnt_force_val;
      full    = (m_fifo.size() == DEPTH);
      empty   = (m_fifo.size() == 0);
      pop     = !empty && char_ready_i;
      ridx    = add_i[4:2];
      pc_wr   = req_i && !wen_i && (ridx == 3'd1);
      exp_gnt = req_i && !(pc_wr && full && !pop);

      check("gnt_o",        gnt_o,        exp_gnt);
      check("r_valid_o",    r_valid_o,    m_rv);
      check("r_data_o",     r_data_o,     m_rd);
      check("exit_valid_o", exit_valid_o, m_exit_valid);
      check("exit_code_o",  exit_code_o,  m_exit_code);
      check("char_valid_o", char_valid_o, !empty);
      check("char_o",       char_o,       empty ? 8'h00 : m_fifo[0]);
`ifdef REDMULE_SIM_CTRL_TIMEOUT_EN
      check("timeout_o",    timeout_o,    m_tmo);
`endif

      if (!rst_i) begin
        case (ridx)
          3'd0:    rv = m_exit_code;
          3'd1:    rv = m_fifo.size();
          3'd2:    rv = m_cnt[31:0];
          3'd3:    rv = m_shadow;
          3'd4:    rv = {29'b0, m_exit_valid, full, empty};
          default: rv = '0;
        endcase
        m_rv = exp_gnt;
        m_rd = (exp_gnt && wen_i) ? rv : 32'h0;
        if (exp_gnt && wen_i && ridx == 3'd2) m_shadow = m_cnt[63:32];
        if (pop) void'(m_fifo.pop_front());
        if (exp_gnt && pc_wr && be_i[0]) m_fifo.push_back(data_i[7:0]);
`ifdef REDMULE_SIM_CTRL_TIMEOUT_EN
        if (!m_exit_valid) begin
          m_wd++;
          if (m_wd == TMO) begin
            m_tmo        = 1'b1;
            m_exit_valid = 1'b1;
            m_exit_code  = 32'hDEAD_0001;
          end
        end
`endif
        if (exp_gnt && !wen_i && ridx == 3'd0) begin
          m_exit_valid = 1'b1;
          m_exit_code  = data_i;
        end
        if (!cnt_forced) m_cnt = m_cnt + 64'd1;
      end
    end
  end

  // --------------------------------------------------------------- driver ---
  // One transaction: present at a negedge, hold until granted (bounded), then
  // deassert and return the response data seen the cycle after the grant.
  task automatic xact(input logic rd, input logic [2:0] idx, input logic [3:0] be,
                      input logic [31:0] d, output logic [31:0] q);
    int waited;
    waited = 0;
    @(negedge clk);
    req_i  = 1'b1;
    wen_i  = rd;
    add_i  = 32'h8000_0000 | {27'd0, idx, 2'b00};
    be_i   = be;
    data_i = d;
    #2;
    while (!gnt_o && waited < 200) begin
      @(negedge clk);
      #2;
      waited++;
    end
    if (!gnt_o) begin
      checks++;
      failures++;
      $display("FAIL gnt_wait: no grant within 200 cycles, expected a grant");
    end
    @(negedge clk);
    req_i  = 1'b0;
    wen_i  = 1'b0;
    add_i  = '0;
    be_i   = '0;
    data_i = '0;
    #2;
    check("resp_valid", r_valid_o, 1'b1);
    q = r_data_o;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL sim_timeout: bench did not finish, expected completion");
    $fatal(1, "simulation time limit");
  end

  byte unsigned hi_str[3] = '{8'h48, 8'h69, 8'h0A};

  initial begin : stim
    logic [31:0] q;
    rst_i = 1'b1; req_i = 1'b0; add_i = '0; wen_i = 1'b0; be_i = '0;
    data_i = '0; char_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    // 1. Reset state and EXIT read.
    xact(1'b1, 3'd0, 4'hF, 32'h0, q);
    check("t1_exit_rd", q, 32'hFFFF_FFFF);
    check("t1_exit_valid", exit_valid_o, 1'b0);

    // 2. EXIT writes; second write overwrites, valid stays.
    xact(1'b0, 3'd0, 4'h0, 32'h0, q);
    check("t2_wr_rdata", q, 32'h0);
    check("t2_exit_valid", exit_valid_o, 1'b1);
    check("t2_exit_code0", exit_code_o, 32'h0);
    xact(1'b0, 3'd0, 4'hF, 32'd5, q);
    check("t2_exit_code5", exit_code_o, 32'd5);
    check("t2_exit_valid2", exit_valid_o, 1'b1);

    // Unmapped index: read zero, write ignored but granted.
    xact(1'b0, 3'd6, 4'hF, 32'h1234_5678, q);
    xact(1'b1, 3'd6, 4'hF, 32'h0, q);
    check("unmapped_rd", q, 32'h0);

    // Putchar write with be_i[0]=0 does not push.
    xact(1'b0, 3'd1, 4'b1110, 32'h55, q);
    xact(1'b1, 3'd1, 4'hF, 32'h0, q);
    check("be0_no_push_count", q, 32'd0);

    // 3. "Hi\n" back to back with the consumer always ready.
    @(negedge clk);
    char_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      req_i = 1'b1; wen_i = 1'b0; add_i = 32'h8000_0004; be_i = 4'h1;
      data_i = {24'h0, hi_str[i]};
      #2;
      check("t3_gnt", gnt_o, 1'b1);
      if (i > 0) check("t3_char", char_o, hi_str[i-1]);
    end
    @(negedge clk);
    req_i = 1'b0; add_i = '0; be_i = '0; data_i = '0;
    #2;
    check("t3_char_last", char_o, 8'h0A);
    @(negedge clk);
    char_ready_i = 1'b0;

    // 4. Fill the FIFO, stall the 17th write, release it with a single pop.
    for (int i = 0; i < DEPTH; i++) xact(1'b0, 3'd1, 4'h1, 32'h60 + i, q);
    xact(1'b1, 3'd4, 4'hF, 32'h0, q);
    check("t4_status_full", q, 32'b110);
    xact(1'b1, 3'd1, 4'hF, 32'h0, q);
    check("t4_count16", q, 32'd16);
    @(negedge clk);
    req_i = 1'b1; wen_i = 1'b0; add_i = 32'h8000_0004; be_i = 4'h1; data_i = 32'h7F;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("t4_stall", gnt_o, 1'b0);
      @(negedge clk);
    end
    char_ready_i = 1'b1;
    #2;
    check("t4_gnt_on_pop", gnt_o, 1'b1);
    @(negedge clk);
    char_ready_i = 1'b0; req_i = 1'b0; add_i = '0; be_i = '0; data_i = '0;
    #2;
    check("t4_head_after_pop", char_o, 8'h61);
    xact(1'b1, 3'd1, 4'hF, 32'h0, q);
    check("t4_count_still16", q, 32'd16);
    @(negedge clk);
    char_ready_i = 1'b1;
    repeat (DEPTH + 1) @(negedge clk);
    char_ready_i = 1'b0;
    #2;
    check("t4_drained", char_valid_o, 1'b0);

    // 5. Coherent 64-bit read across a carry.
    @(negedge clk);
    cnt_force_val = 64'h0000_0001_FFFF_FFFF;
    cnt_forced    = 1'b1;
    force dut.cnt = 64'h0000_0001_FFFF_FFFF;
    xact(1'b1, 3'd2, 4'hF, 32'h0, q);
    check("t5_lo", q, 32'hFFFF_FFFF);
    @(negedge clk);
    release dut.cnt;
    cnt_forced = 1'b0;
    xact(1'b1, 3'd3, 4'hF, 32'h0, q);
    check("t5_hi", q, 32'h1);
    xact(1'b1, 3'd2, 4'hF, 32'h0, q);

    // 6. Reset with a read in flight and three bytes buffered.
    for (int i = 0; i < 3; i++) xact(1'b0, 3'd1, 4'h1, 32'h41 + i, q);
    @(negedge clk);
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h8000_0000; be_i = 4'hF;
    #3;
    rst_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0; wen_i = 1'b0; add_i = '0; be_i = '0;
    #2;
    check("t6_rvalid", r_valid_o, 1'b0);
    check("t6_char_valid", char_valid_o, 1'b0);
    check("t6_exit_code", exit_code_o, 32'hFFFF_FFFF);
    check("t6_exit_valid", exit_valid_o, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;

`ifdef REDMULE_SIM_CTRL_TIMEOUT_EN
    repeat (TMO - 1) @(negedge clk);
    #2;
    check("wd_before", timeout_o, 1'b0);
    @(negedge clk);
    #2;
    check("wd_fired", timeout_o, 1'b1);
    check("wd_code", exit_code_o, 32'hDEAD_0001);
    check("wd_exit_valid", exit_valid_o, 1'b1);
    xact(1'b0, 3'd0, 4'hF, 32'd7, q);
    check("wd_exit_overwrite", exit_code_o, 32'd7);
    check("wd_sticky", timeout_o, 1'b1);
`else
    repeat (4) @(negedge clk);
`endif

    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_redmule_sim_ctrl
